// File: rtl/vga_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fill_engine
//  Purpose  : Bus-mapped rectangle fill for frame-buffer port A, sharing the
//             port with a CPU single-write path (CPU has fixed priority).
//  Revision : 1.0  initial release
// ============================================================================
module vga_fill_engine #(
   parameter logic [7:0] BASE_ADDR = 8'hC0,
   parameter int         X_MAX     = 159,
   parameter int         Y_MAX     = 119
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  BUS_ADDR,
   inout  wire  [7:0]  BUS_DATA,
   input  logic        BUS_WE,
   input  logic        CPU_FB_REQ,
   input  logic [14:0] CPU_FB_ADDR,
   input  logic [7:0]  CPU_FB_DATA,
   output logic        CPU_FB_GNT,
   output logic [14:0] FB_ADDR,
   output logic [7:0]  FB_DATA,
   output logic        FB_WE,
   output logic        BUSY,
   output logic        DONE_IRQ
);

   localparam logic [7:0] X_LIM = 8'(X_MAX);
   localparam logic [7:0] Y_LIM = 8'(Y_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d, fill_q, fill_d;
   logic [7:0]  gx0_q, gx0_d, gy0_q, gy0_d, gx1_q, gx1_d, gy1_q, gy1_d;
   logic [7:0]  gfill_q, gfill_d;
   logic [7:0]  x_q, x_d, y_q, y_d;
   logic        err_q, err_d;
   logic        fb_we_q, fb_we_d;
   logic [14:0] fb_addr_q, fb_addr_d;
   logic [7:0]  fb_data_q, fb_data_d;
   logic [7:0]  rd_data_q, rd_data_d, rd_addr_q, rd_addr_d;
   logic        rd_en_q, rd_en_d;

   logic [7:0]  offset;
   logic        owned, wr_sel, start_wr, abort_wr, busy;
   logic [7:0]  x1_clamp, y1_clamp;
   logic        geom_err;

   assign offset   = BUS_ADDR - BASE_ADDR;
   assign owned    = (offset < 8'd6);
   assign wr_sel   = BUS_WE && owned;
   assign start_wr = wr_sel && (offset == 8'd5) && BUS_DATA[0];
   assign abort_wr = wr_sel && (offset == 8'd5) && BUS_DATA[1];
   assign busy     = (state_q != S_IDLE);

   assign x1_clamp = (gx1_q > X_LIM) ? X_LIM : gx1_q;
   assign y1_clamp = (gy1_q > Y_LIM) ? Y_LIM : gy1_q;
   assign geom_err = (gx0_q > X_LIM) || (gy0_q > Y_LIM) ||
                     (gx0_q > x1_clamp) || (gy0_q > y1_clamp);

   always_comb begin
      state_d   = state_q;
      x0_d      = x0_q;
      y0_d      = y0_q;
      x1_d      = x1_q;
      y1_d      = y1_q;
      fill_d    = fill_q;
      gx0_d     = gx0_q;
      gy0_d     = gy0_q;
      gx1_d     = gx1_q;
      gy1_d     = gy1_q;
      gfill_d   = gfill_q;
      x_d       = x_q;
      y_d       = y_q;
      err_d     = err_q;
      fb_we_d   = 1'b0;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;

      if (wr_sel) begin
         case (offset)
            8'd0: if (!busy) x0_d = BUS_DATA;
            8'd1: if (!busy) y0_d = BUS_DATA;
            8'd2: if (!busy) x1_d = BUS_DATA;
            8'd3: if (!busy) y1_d = BUS_DATA;
            8'd4: fill_d = BUS_DATA;
            default: ;
         endcase
      end

      // CPU owns the port whenever it asks; the engine simply retries later.
      if (CPU_FB_REQ) begin
         fb_we_d   = 1'b1;
         fb_addr_d = CPU_FB_ADDR;
         fb_data_d = CPU_FB_DATA;
      end

      case (state_q)
         S_IDLE: begin
            if (start_wr && !abort_wr) begin
               gx0_d   = x0_q;
               gy0_d   = y0_q;
               gx1_d   = x1_q;
               gy1_d   = y1_q;
               gfill_d = fill_q;
               err_d   = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (abort_wr) begin
               state_d = S_IDLE;
            end else if (geom_err) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               gx1_d   = x1_clamp;
               gy1_d   = y1_clamp;
               x_d     = gx0_q;
               y_d     = gy0_q;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort_wr) begin
               state_d = S_IDLE;
            end else if (!CPU_FB_REQ) begin
               fb_we_d   = 1'b1;
               fb_addr_d = {y_q[6:0], x_q};
               fb_data_d = gfill_q;
               if (x_q == gx1_q) begin
                  if (y_q == gy1_q) begin
                     state_d = S_DONE;
                  end else begin
                     x_d = gx0_q;
                     y_d = y_q + 8'd1;
                  end
               end else begin
                  x_d = x_q + 8'd1;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Read data is captured one cycle ahead and only shown while the same
   // owned address is still being read.
   always_comb begin
      rd_en_d   = owned && !BUS_WE;
      rd_addr_d = BUS_ADDR;
      case (offset)
         8'd0:    rd_data_d = x0_q;
         8'd1:    rd_data_d = y0_q;
         8'd2:    rd_data_d = x1_q;
         8'd3:    rd_data_d = y1_q;
         8'd4:    rd_data_d = fill_q;
         8'd5:    rd_data_d = {6'b0, err_q, busy};
         default: rd_data_d = 8'h00;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         x0_q      <= 8'h00;
         y0_q      <= 8'h00;
         x1_q      <= 8'h00;
         y1_q      <= 8'h00;
         fill_q    <= 8'h00;
         gx0_q     <= 8'h00;
         gy0_q     <= 8'h00;
         gx1_q     <= 8'h00;
         gy1_q     <= 8'h00;
         gfill_q   <= 8'h00;
         x_q       <= 8'h00;
         y_q       <= 8'h00;
         err_q     <= 1'b0;
         fb_we_q   <= 1'b0;
         fb_addr_q <= 15'h0000;
         fb_data_q <= 8'h00;
         rd_data_q <= 8'h00;
         rd_addr_q <= 8'h00;
         rd_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         x0_q      <= x0_d;
         y0_q      <= y0_d;
         x1_q      <= x1_d;
         y1_q      <= y1_d;
         fill_q    <= fill_d;
         gx0_q     <= gx0_d;
         gy0_q     <= gy0_d;
         gx1_q     <= gx1_d;
         gy1_q     <= gy1_d;
         gfill_q   <= gfill_d;
         x_q       <= x_d;
         y_q       <= y_d;
         err_q     <= err_d;
         fb_we_q   <= fb_we_d;
         fb_addr_q <= fb_addr_d;
         fb_data_q <= fb_data_d;
         rd_data_q <= rd_data_d;
         rd_addr_q <= rd_addr_d;
         rd_en_q   <= rd_en_d;
      end
   end

   assign BUS_DATA = (rd_en_q && owned && !BUS_WE && (BUS_ADDR == rd_addr_q)) ?
                     rd_data_q : 8'hzz;

   assign CPU_FB_GNT = CPU_FB_REQ;
   assign FB_WE      = fb_we_q;
   assign FB_ADDR    = fb_addr_q;
   assign FB_DATA    = fb_data_q;
   assign BUSY       = busy;
   assign DONE_IRQ   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_vga_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fill_engine
//  Purpose  : Randomized self-checking bench for vga_fill_engine against a
//             transaction-level model of the expected port-A write stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_fill_engine;

   localparam logic [7:0] BASE = 8'hC0;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  bus_addr;
   logic        bus_we;
   logic        tb_drv_en;
   logic [7:0]  tb_drv;
   wire  [7:0]  bus_data;
   logic        cpu_req;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_gnt;
   logic [14:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_we;
   logic        busy;
   logic        done_irq;

   int n_checks = 0;
   int n_errors = 0;

   logic [14:0] eng_q[$];

   assign bus_data = tb_drv_en ? tb_drv : 8'hzz;
   pullup (bus_data);

   always #5 clk = ~clk;

   vga_fill_engine dut (
      .CLK         (clk),
      .RESET       (reset),
      .BUS_ADDR    (bus_addr),
      .BUS_DATA    (bus_data),
      .BUS_WE      (bus_we),
      .CPU_FB_REQ  (cpu_req),
      .CPU_FB_ADDR (cpu_addr),
      .CPU_FB_DATA (cpu_data),
      .CPU_FB_GNT  (cpu_gnt),
      .FB_ADDR     (fb_addr),
      .FB_DATA     (fb_data),
      .FB_WE       (fb_we),
      .BUSY        (busy),
      .DONE_IRQ    (done_irq)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      bus_addr  = addr;
      bus_we    = 1'b1;
      tb_drv    = data;
      tb_drv_en = 1'b1;
      @(negedge clk);
      bus_we    = 1'b0;
      tb_drv_en = 1'b0;
      bus_addr  = 8'h00;
   endtask

   task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
      @(negedge clk);
      bus_addr = addr;
      bus_we   = 1'b0;
      @(negedge clk);
      data     = bus_data;
      bus_addr = 8'h00;
   endtask

   // cpu_mode: 0 none, 1 random requests, 2 requests in cycles 3 and 4.
   // stop_after >= 0 aborts (or resets) once that many engine writes issued.
   task automatic run_fill(input int x0, input int y0, input int x1, input int y1,
                           input logic [7:0] fill, input int cpu_mode,
                           input int stop_after, input bit use_reset);
      int          c, idx, n, last_c, stop_c, x1c, y1c;
      bit          last_known, err, req;
      logic        pe_we;
      logic [14:0] pe_addr;
      logic [7:0]  pe_data, rd;

      x1c = (x1 > 159) ? 159 : x1;
      y1c = (y1 > 119) ? 119 : y1;
      err = (x0 > 159) || (y0 > 119) || (x0 > x1c) || (y0 > y1c);
      eng_q.delete();
      if (!err)
         for (int yy = y0; yy <= y1c; yy++)
            for (int xx = x0; xx <= x1c; xx++)
               eng_q.push_back(15'(yy * 256 + xx));
      n = eng_q.size();

      bus_write(BASE + 8'd0, 8'(x0));
      bus_write(BASE + 8'd1, 8'(y0));
      bus_write(BASE + 8'd2, 8'(x1));
      bus_write(BASE + 8'd3, 8'(y1));
      bus_write(BASE + 8'd4, fill);

      bus_addr  = BASE + 8'd5;
      bus_we    = 1'b1;
      tb_drv    = 8'h01;
      tb_drv_en = 1'b1;
      cpu_req   = 1'b0;
      pe_we = 1'b0; pe_addr = '0; pe_data = '0;
      c = 0; idx = 0; last_known = err; last_c = 1; stop_c = -1;

      forever begin
         @(negedge clk);
         c++;
         bus_we    = 1'b0;
         tb_drv_en = 1'b0;
         bus_addr  = 8'h00;
         reset     = 1'b0;

         check_val("fb_we", fb_we, pe_we);
         if (pe_we) begin
            check_val("fb_addr", fb_addr, pe_addr);
            check_val("fb_data", fb_data, pe_data);
         end
         if (stop_c < 0) begin
            check_val("done_irq", done_irq, last_known && (c == last_c + 1));
            check_val("busy", busy, !(last_known && (c >= last_c + 2)));
         end else begin
            check_val("stop_busy", busy, 0);
            check_val("stop_irq", done_irq, 0);
            if (use_reset && c == stop_c + 1) check_val("rst_fb_addr", fb_addr, 0);
         end

         if ((stop_c < 0 && last_known && c >= last_c + 3) || (stop_c >= 0 && c >= stop_c + 3)) begin
            cpu_req = 1'b0;
            break;
         end
         if (c > 25000) begin
            check_val("timeout", 1, 0);
            cpu_req = 1'b0;
            break;
         end

         req = 1'b0;
         if (stop_c < 0) begin
            if (cpu_mode == 1) req = ($urandom_range(0, 4) == 0);
            if (cpu_mode == 2) req = (c == 3 || c == 4);
         end
         if (stop_c < 0 && stop_after >= 0 && c >= 2 && idx == stop_after) begin
            stop_c = c;
            req    = 1'b0;
            if (use_reset) reset = 1'b1;
            else begin
               bus_addr  = BASE + 8'd5;
               bus_we    = 1'b1;
               tb_drv    = 8'h02;
               tb_drv_en = 1'b1;
            end
         end
         cpu_req = req;
         if (req) begin
            cpu_addr = (cpu_mode == 2) ? 15'h1234 : 15'($urandom);
            cpu_data = (cpu_mode == 2) ? 8'h3C : 8'($urandom);
         end

         if (req) begin
            pe_we = 1'b1; pe_addr = cpu_addr; pe_data = cpu_data;
         end else if (stop_c < 0 && !err && c >= 2 && idx < n) begin
            pe_we = 1'b1; pe_addr = eng_q[idx]; pe_data = fill;
            idx++;
            if (idx == n) begin
               last_known = 1'b1;
               last_c     = c;
            end
         end else begin
            pe_we = 1'b0;
         end
      end

      if (stop_c < 0) begin
         check_val("engine_writes", idx, n);
         bus_read(BASE + 8'd5, rd);
         check_val("status", rd, err ? 8'h02 : 8'h00);
      end else if (use_reset) begin
         for (int i = 0; i < 6; i++) begin
            bus_read(BASE + 8'(i), rd);
            check_val("rst_reg", rd, 8'h00);
         end
      end else begin
         bus_read(BASE + 8'd5, rd);
         check_val("abort_status", rd, 8'h00);
      end
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] vals[5];

      reset = 1'b1; bus_addr = 8'h00; bus_we = 1'b0; tb_drv_en = 1'b0; tb_drv = 8'h00;
      cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_val("rst_fb_we", fb_we, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_irq", done_irq, 0);
      check_val("rst_fb_addr", fb_addr, 0);
      for (int i = 0; i < 6; i++) begin
         bus_read(BASE + 8'(i), rd);
         check_val("rst_reg", rd, 8'h00);
      end

      // Register readback, then bus release on an unowned address.
      for (int i = 0; i < 5; i++) begin
         vals[i] = 8'($urandom_range(1, 254));
         bus_write(BASE + 8'(i), vals[i]);
      end
      for (int i = 0; i < 5; i++) begin
         bus_read(BASE + 8'(i), rd);
         check_val("reg_rw", rd, vals[i]);
      end
      @(negedge clk);
      bus_addr = 8'h10;
      @(negedge clk);
      check_val("bus_release", (bus_data === 8'hFF) || (bus_data === 8'hzz), 1);
      check_val("gnt", cpu_gnt, 0);
      bus_addr = 8'h00;

      run_fill(2, 3, 4, 4, 8'hA5, 0, -1, 0);
      run_fill(0, 0, 200, 130, 8'h5A, 0, -1, 0);
      run_fill(10, 0, 5, 0, 8'h11, 0, -1, 0);
      run_fill(2, 3, 4, 4, 8'hA5, 2, -1, 0);
      run_fill(7, 7, 7, 7, 8'hEE, 0, -1, 0);
      run_fill(2, 3, 4, 4, 8'hA5, 0, 3, 0);
      run_fill(2, 3, 4, 4, 8'hA5, 0, 3, 1);

      for (int t = 0; t < 12; t++) begin
         int x0, y0, x1, y1;
         x0 = $urandom_range(140, 165);
         y0 = $urandom_range(112, 122);
         x1 = ($urandom_range(0, 5) == 0) ? 255 : x0 + $urandom_range(0, 12) - 2;
         y1 = ($urandom_range(0, 5) == 0) ? 255 : y0 + $urandom_range(0, 5) - 1;
         run_fill(x0, y0, x1, y1, 8'($urandom), 1, -1, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_fill_engine.md
Name: vga_fill_engine

Overview:
Bus-mapped rectangle-fill controller for the VGA frame buffer's write port (port A). The CPU programs corner coordinates and a fill byte over the 8-bit bus, then starts the engine. The engine sequences one frame-buffer write per cycle in row-major order. It shares port A with a direct CPU single-write path through a fixed-priority arbiter and raises an interrupt pulse on completion.

Parameters:
BASE_ADDR, 8'hC0, bus address of register 0; registers occupy BASE_ADDR..BASE_ADDR+5.
X_MAX, 159, largest legal column index.
Y_MAX, 119, largest legal row index.

Ports:
CLK  in  1  system clock, 50 MHz.
RESET  in  1  synchronous, active-high reset.
BUS_ADDR  in  8  CPU bus address.
BUS_DATA  inout  8  CPU bus data. Driven only during a read of an owned address, otherwise Z.
BUS_WE  in  1  CPU bus write enable.
CPU_FB_REQ  in  1  direct CPU frame-buffer write request, single cycle.
CPU_FB_ADDR  in  15  direct write address, {y[6:0], x[7:0]}.
CPU_FB_DATA  in  8  direct write data.
CPU_FB_GNT  out  1  combinational grant, equal to CPU_FB_REQ.
FB_ADDR  out  15  frame-buffer port A address.
FB_DATA  out  8  frame-buffer port A data.
FB_WE  out  1  frame-buffer port A write enable.
BUSY  out  1  high while the FSM is not IDLE.
DONE_IRQ  out  1  one-cycle completion pulse.

Behaviour:
- Register map, offset from BASE_ADDR:
  - 0 X0, 1 Y0, 2 X1, 3 Y1, 4 FILL: R/W, 8-bit.
  - 5 CTRL/STATUS. Write bit0 = START, bit1 = ABORT. Read returns {6'b0, ERR, BUSY}.
- Bus read protocol:
  - Register value appears on BUS_DATA in the cycle after the address is presented.
  - BUS_DATA is driven only while the owned address is held with BUS_WE=0.
  - Bus writes are captured at the clock edge.
- Coordinate writes while BUSY=1 are ignored. Running geometry is latched at START.
- Reset (synchronous):
  - X0=Y0=X1=Y1=0, FILL=0, ERR=0, FSM=IDLE.
  - FB_WE=0, FB_ADDR=0, FB_DATA=0, BUSY=0, DONE_IRQ=0, bus released (Z).
  - Reset mid-fill aborts immediately. No further FB_WE and no DONE_IRQ.
- FSM states: IDLE, CHECK, RUN, DONE.
  - IDLE: a START write (cycle N) latches geometry, clears ERR, and moves to CHECK.
  - CHECK (cycle N+1):
    - Clamp X1 to X_MAX and Y1 to Y_MAX.
    - If X0>X_MAX, Y0>Y_MAX, X0>X1 or Y0>Y1: set ERR and go to DONE. Zero writes occur.
    - Otherwise load x=X0, y=Y0 and go to RUN.
  - RUN: each cycle in which the engine holds port A issues one write.
    - FB_ADDR = {y[6:0], x[7:0]}, FB_DATA = FILL, FB_WE = 1.
    - The first engine write is registered at the N+2 edge.
    - Ordering: x increments. At x==X1, x reloads X0 and y increments.
    - After the write at (X1,Y1), go to DONE.
  - DONE: DONE_IRQ=1 for exactly one cycle, then IDLE. BUSY drops in the IDLE cycle.
- ABORT:
  - An ABORT write in CHECK or RUN goes to IDLE next cycle, with no DONE_IRQ and ERR unchanged.
  - ABORT in IDLE is a no-op.
  - START and ABORT written together: ABORT wins.
  - START while BUSY is ignored.
- Arbitration (fixed priority, CPU first):
  - When CPU_FB_REQ=1, port A carries CPU_FB_ADDR and CPU_FB_DATA with FB_WE=1, registered next edge.
  - In that cycle the engine stalls: x and y hold and the pending write is retried.
  - CPU requests are accepted in every FSM state.
- Port A outputs are registered. FB_WE=0 in any cycle with no grant.
- Write count equals (X1c−X0+1)·(Y1c−Y0+1) exactly, with no duplicates and no skips.
  - X1c and Y1c are the clamped corners.
  - Counters are 8-bit. Clamping guarantees no wrap past 255.
- Single-pixel rectangle (X0=X1, Y0=Y1): one write, then DONE.

Test Plan:
1. Reset, then read offsets 0–5 -> all read 8'h00; FB_WE=0; BUSY=0; BUS_DATA Z when an unowned address is presented.
2. X0=2, Y0=3, X1=4, Y1=4, FILL=8'hA5, START -> 6 writes of A5 on consecutive cycles to 0x0302, 0x0303, 0x0304, 0x0402, 0x0403, 0x0404; first FB_WE at START+2; one DONE_IRQ pulse; STATUS=0 afterwards.
3. Fill X0=0, Y0=0, X1=200, Y1=130 -> clamped to 159/119; exactly 19200 writes; last address 0x779F; ERR=0.
4. X0=10, X1=5, START -> no FB_WE; DONE_IRQ pulse; STATUS reads 8'h02.
5. During the scenario-2 fill, assert CPU_FB_REQ for 2 cycles with addr 0x1234, data 0x3C -> two CPU writes appear; engine sequence resumes unaltered; total engine writes still 6; completion delayed by 2 cycles.
6. ABORT written mid-fill after 3 writes -> no further engine writes; no DONE_IRQ; BUSY=0 next cycle. Repeat, asserting RESET mid-fill instead -> same result, and all registers read 0.
